// File: rtl/booth_arb_pkg.sv
// booth_arb_pkg: shared constants for the Booth multiplier arbiter.
// State encoding plus operand and product widths.
package booth_arb_pkg;

  localparam int OPW = 4;
  localparam int PW  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Grants the first set request at or above ptr, wrapping.
module rr_pick
  import booth_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt_onehot,
  output logic [IDW-1:0]  gnt_idx,
  output logic            any
);

  // scan offsets from ptr upward; first hit wins
  always_comb begin
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      for (int j = 0; j < NREQ; j++) begin
        if (!any && req[j] &&
            ((int'(ptr) + i) % NREQ) == j) begin
          any           = 1'b1;
          gnt_onehot[j] = 1'b1;
          gnt_idx       = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: shares one Booth multiplier among NREQ requesters.
// Optional macro BOOTH_ARB_ZERO_BYPASS_EN skips the multiplier on zero operands.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int MUL_LAT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [OPW*NREQ-1:0] req_a,
  input  logic [OPW*NREQ-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [PW-1:0]       rsp_result,
  output logic                mul_start,
  output logic [OPW-1:0]      mul_a,
  output logic [OPW-1:0]      mul_b,
  input  logic [PW-1:0]       mul_result,
  output logic                busy
);

  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [OPW-1:0] a_q, a_d;
  logic [OPW-1:0] b_q, b_d;
  logic [PW-1:0]  res_q, res_d;

  logic [NREQ-1:0] gnt;
  logic [IDW-1:0]  gidx;
  logic            any;
  logic [OPW-1:0]  sel_a, sel_b;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .req       (req_valid),
    .ptr       (ptr_q),
    .gnt_onehot(gnt),
    .gnt_idx   (gidx),
    .any       (any)
  );

  // route the granted requester's operands
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (gnt[j]) begin
        sel_a = req_a[j*OPW +: OPW];
        sel_b = req_b[j*OPW +: OPW];
      end
    end
  end

  // next state and datapath updates
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    unique case (state_q)
      ST_IDLE: begin
        if (any) begin
          a_d     = sel_a;
          b_d     = sel_b;
          id_d    = gidx;
          ptr_d   = (gidx == IDW'(NREQ-1)) ? '0
                                           : gidx + 1'b1;
          cnt_d   = '0;
          state_d = ST_RUN;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
          if (sel_a == '0 || sel_b == '0) begin
            res_d   = '0;
            state_d = ST_DONE;
          end
`endif
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_LAT-1)) begin
          res_d   = mul_result;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers, sync reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE && !reset) ? gnt : '0;
  assign rsp_valid  = (state_q == ST_DONE);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign mul_start  = (state_q == ST_RUN);
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb_booth_mul_arbiter: scoreboard bench with a latency-accurate multiplier.
// Honours BOOTH_ARB_ZERO_BYPASS_EN for expected latency of zero operands.
module tb_booth_mul_arbiter;

  localparam int NREQ    = 4;
  localparam int IDW     = 2;
  localparam int MUL_LAT = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [4*NREQ-1:0] req_a, req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [7:0]        rsp_result;
  logic              mul_start;
  logic [3:0]        mul_a, mul_b;
  logic [7:0]        mul_result;
  logic              busy;

  always #5 clk = ~clk;

  booth_mul_arbiter #(
    .NREQ   (NREQ),
    .IDW    (IDW),
    .MUL_LAT(MUL_LAT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_result(rsp_result),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_result(mul_result),
    .busy      (busy)
  );

  function automatic logic [7:0] prod(logic [3:0] a, logic [3:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return 8'(p);
  endfunction

  // multiplier: product valid only from the MUL_LAT-th start-high cycle
  int mcnt = 0;
  always @(posedge clk) mcnt <= mul_start ? mcnt + 1 : 0;

  always_comb begin
    mul_result = 8'hA5;
    if (mul_start && mcnt >= MUL_LAT-1)
      mul_result = prod(mul_a, mul_b);
  end

  typedef struct {
    int         id;
    logic [7:0] res;
    logic [3:0] a;
    logic [3:0] b;
    int         acc;
    int         due;
    bit         byp;
  } exp_t;

  exp_t       q[$];
  int         nvec = 0;
  int         nerr = 0;
  int         cyc  = 0;
  int         mptr = 0;
  bit         bp   = 1'b0;
  bit         rnd  = 1'b0;
  bit         pend_v[NREQ];
  logic [3:0] pend_a[NREQ];
  logic [3:0] pend_b[NREQ];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               nm, cyc, act, exp);
    end
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++) begin
      int j;
      j = (mptr + k) % NREQ;
      if (pend_v[j]) return j;
    end
    return -1;
  endfunction

  task automatic setreq(int i, logic [3:0] a, logic [3:0] b);
    pend_v[i] = 1'b1;
    pend_a[i] = a;
    pend_b[i] = b;
  endtask

  // one cycle: drive at negedge, then check grant against the model
  task automatic step();
    logic [NREQ-1:0] exp_rdy;
    int g;
    exp_t e;
    @(negedge clk);
    cyc++;
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (rnd && pend_v[i] && $urandom_range(0, 19) == 0)
        pend_v[i] = 1'b0;
      req_valid[i]     = pend_v[i];
      req_a[i*4 +: 4]  = pend_a[i];
      req_b[i*4 +: 4]  = pend_b[i];
    end
    rsp_ready = bp  ? 1'b0 :
                rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
    #1;
    exp_rdy = '0;
    g = -1;
    if (q.size() == 0) g = pick();
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (g >= 0) begin
      e.id  = g;
      e.a   = pend_a[g];
      e.b   = pend_b[g];
      e.res = prod(pend_a[g], pend_b[g]);
      e.acc = cyc;
      e.byp = 1'b0;
`ifdef BOOTH_ARB_ZERO_BYPASS_EN
      e.byp = (pend_a[g] == 4'd0) || (pend_b[g] == 4'd0);
`endif
      e.due = cyc + (e.byp ? 1 : MUL_LAT + 1);
      q.push_back(e);
      mptr = (g + 1) % NREQ;
      pend_v[g] = 1'b0;
    end
  endtask

  task automatic steps(int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // reset for n edges; everything must read zero after each edge
  task automatic do_reset(int n);
    @(negedge clk);
    reset = 1'b1;
    rsp_ready = 1'b0;
    q.delete();
    mptr = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
      chk("rst_rsp_result", 32'(rsp_result), 0);
      chk("rst_mul_start", 32'(mul_start), 0);
      chk("rst_mul_a", 32'(mul_a), 0);
      chk("rst_mul_b", 32'(mul_b), 0);
      chk("rst_busy", 32'(busy), 0);
    end
  endtask

  // monitor: compares outputs to the scoreboard head each cycle
  initial begin
    bit ev, es, eb;
    forever begin
      @(negedge clk);
      #2;
      if (reset) continue;
      ev = 1'b0;
      es = 1'b0;
      eb = 1'b0;
      if (q.size() != 0) begin
        ev = (cyc >= q[0].due);
        es = !q[0].byp && cyc >= q[0].acc + 1 &&
             cyc <= q[0].acc + MUL_LAT;
        eb = (cyc > q[0].acc);
      end
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("mul_start", 32'(mul_start), 32'(es));
      chk("busy", 32'(busy), 32'(eb));
      if (es) begin
        chk("mul_a", 32'(mul_a), 32'(q[0].a));
        chk("mul_b", 32'(mul_b), 32'(q[0].b));
      end
      if (ev) begin
        chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
        chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
        if (rsp_valid && rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend_v[i] = 1'b0;
      pend_a[i] = '0;
      pend_b[i] = '0;
    end
    do_reset(2);

    setreq(0, 4'd4, 4'd5);
    steps(10);
    setreq(1, 4'hD, 4'd5);
    steps(8);
    setreq(2, 4'h8, 4'h8);
    steps(8);

    do_reset(1);
    setreq(0, 4'd1, 4'd2);
    setreq(1, 4'd3, 4'hF);
    setreq(2, 4'h9, 4'd7);
    setreq(3, 4'h7, 4'h7);
    steps(7);
    setreq(0, 4'hA, 4'h6);
    steps(30);

    bp = 1'b1;
    setreq(3, 4'd7, 4'hE);
    steps(2);
    setreq(1, 4'd2, 4'd2);
    steps(14);
    bp = 1'b0;
    steps(10);

    setreq(2, 4'd3, 4'd3);
    steps(3);
    do_reset(2);
    for (int i = 0; i < NREQ; i++)
      setreq(i, 4'(i + 1), 4'hC);
    steps(40);

    setreq(1, 4'd0, 4'd7);
    steps(8);

    rnd = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NREQ; i++)
        if (!pend_v[i] && $urandom_range(0, 3) == 0)
          setreq(i, 4'($urandom), 4'($urandom));
      step();
    end

    rnd = 1'b0;
    for (int i = 0; i < NREQ; i++) pend_v[i] = 1'b0;
    for (int k = 0; k < 100 && q.size() != 0; k++) step();
    steps(2);
    chk("drain_empty", 32'(q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
